step_monitor: RTL and testbench

Receive-side counterpart of the step-pulse generator.
- Samples a motor step/dir pair asynchronously, detects step rising edges and tracks signed position.
- Per move: counts steps and measures the inter-step period in clk cycles, including last, minimum and maximum values.
- Flags completion against an expected step count, a stall timeout, and overrun.
- Sits beside each axis driver for closed-loop checking and host-side telemetry.

---
 rtl/step_monitor_pkg.sv | 19 +
 rtl/step_monitor_if.sv | 33 +++
 rtl/step_edge_sync.sv | 33 +++
 rtl/step_monitor.sv | 143 ++++++++++++++
 tb/tb_step_monitor.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_monitor_pkg.sv
// Shared types and constants for the step/dir receive-side monitor.
package step_monitor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFirst,
    StMeasure,
    StDone,
    StStall
  } state_e;

  localparam int unsigned CntWDefault = 32;
  localparam logic [CntWDefault-1:0] AllOnesDefault = '1;

  function automatic logic is_busy(state_e s);
    return (s == StWaitFirst) || (s == StMeasure);
  endfunction

endpackage

// File: rtl/step_monitor_if.sv
// Move-control and telemetry bundle between an axis controller and its step monitor.
interface step_monitor_if
  import step_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
);
  logic             enable;
  logic [CNT_W-1:0] expected_steps;
  logic             step_in;
  logic             dir_in;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] position;
  logic [CNT_W-1:0] last_period;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
  logic             period_valid;
  logic             busy;
  logic             done;
  logic             stall;
  logic             overrun;

  modport master (
    output enable, expected_steps, step_in, dir_in,
    input  step_count, position, last_period, min_period, max_period,
    input  period_valid, busy, done, stall, overrun
  );

  modport slave (
    input  enable, expected_steps, step_in, dir_in,
    output step_count, position, last_period, min_period, max_period,
    output period_valid, busy, done, stall, overrun
  );
endinterface

// File: rtl/step_edge_sync.sv
// Synchronizes an asynchronous step/dir pair and flags step rising edges.
// Also usable for endstop inputs (tie dir_i off).
module step_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  input  logic dir_i,
  output logic edge_o,
  output logic dir_o
);

  logic [STAGES-1:0] step_sync_q;
  logic [STAGES-1:0] dir_sync_q;
  logic              hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      hist_q      <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[STAGES-2:0], step_i};
      dir_sync_q  <= {dir_sync_q[STAGES-2:0], dir_i};
      hist_q      <= step_sync_q[STAGES-1];
    end
  end

  assign edge_o = step_sync_q[STAGES-1] & ~hist_q;
  assign dir_o  = dir_sync_q[STAGES-1];

endmodule

// File: rtl/step_monitor.sv
// Step/dir monitor: tracks position, counts steps per move, measures inter-step
// periods and flags done, stall and overrun.
module step_monitor
  import step_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50_000_000
) (
  input logic           clk_i,
  input logic           rst_ni,
  step_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] Ones       = '1;
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pos_q, pos_d, timer_q, timer_d, exp_q, exp_d;
  logic [CNT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic             pv_q, pv_d, ovr_q, ovr_d, en_q;
  logic             step_edge, dir_sync, timed_out;
  logic [CNT_W-1:0] cnt_inc;

  step_edge_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .step_i(mon.step_in),
    .dir_i (mon.dir_in),
    .edge_o(step_edge),
    .dir_o (dir_sync)
  );

  assign timed_out = (timer_q == TimeoutVal);
  assign cnt_inc   = (cnt_q == Ones) ? cnt_q : cnt_q + One;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    pv_d    = 1'b0;
    ovr_d   = ovr_q;
    exp_d   = exp_q;
    timer_d = step_edge ? One : ((timer_q == Ones) ? timer_q : timer_q + One);
    pos_d   = pos_q;
    if (step_edge) pos_d = dir_sync ? pos_q + One : pos_q - One;

    if (!mon.enable) begin
      // Dropping enable clears the move from any state; position is left alone.
      state_d = StIdle;
      cnt_d   = '0;
      last_d  = '0;
      min_d   = Ones;
      max_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!en_q) begin
            exp_d   = mon.expected_steps;
            timer_d = One;
            state_d = (mon.expected_steps == '0) ? StDone : StWaitFirst;
          end
        end
        StWaitFirst: begin
          if (step_edge) begin
            cnt_d   = One;
            state_d = (exp_q == One) ? StDone : StMeasure;
          end else if (timed_out) begin
            state_d = StStall;
          end
        end
        StMeasure: begin
          if (step_edge) begin
            last_d = timer_q;
            pv_d   = 1'b1;
            cnt_d  = cnt_inc;
            if (timer_q < min_q) min_d = timer_q;
            if (timer_q > max_q) max_d = timer_q;
            if (cnt_inc == exp_q) state_d = StDone;
          end else if (timed_out) begin
            state_d = StStall;
          end
        end
        StDone: begin
          if (step_edge) begin
            cnt_d = cnt_inc;
            ovr_d = 1'b1;
          end
        end
        StStall: begin
          if (step_edge) cnt_d = cnt_inc;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pos_q   <= '0;
      timer_q <= '0;
      exp_q   <= '0;
      last_q  <= '0;
      min_q   <= Ones;
      max_q   <= '0;
      pv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      exp_q   <= exp_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      pv_q    <= pv_d;
      ovr_q   <= ovr_d;
      en_q    <= mon.enable;
    end
  end

  assign mon.step_count   = cnt_q;
  assign mon.position     = pos_q;
  assign mon.last_period  = last_q;
  assign mon.min_period   = min_q;
  assign mon.max_period   = max_q;
  assign mon.period_valid = pv_q;
  assign mon.busy         = is_busy(state_q);
  assign mon.done         = (state_q == StDone);
  assign mon.stall        = (state_q == StStall);
  assign mon.overrun      = ovr_q;

endmodule

// File: tb/tb_step_monitor.sv
// Self-checking bench for step_monitor: directed scenarios plus randomized moves
// checked against a pulse-schedule model.
module tb_step_monitor;
  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  step_monitor_if #(.CNT_W(W))  bus ();
  step_monitor_if #(.CNT_W(W2)) bus2 ();

  step_monitor #(.CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .mon   (bus.slave)
  );

  step_monitor #(.CNT_W(W2), .SYNC_STAGES(2), .TIMEOUT(10)) dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .mon   (bus2.slave)
  );

  int checks = 0;
  int errors = 0;
  int pv_total = 0;
  logic [W-1:0]  pos_model = '0;
  logic [W2-1:0] pos2_model = '0;
  logic [W-1:0]  ones = '1;

  always @(negedge clk) if (bus.period_valid) pv_total <= pv_total + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic pulse(input int hi, input int lo);
    bus.step_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.step_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse2(input int hi, input int lo);
    bus2.step_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus2.step_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.step_count !== '0 || bus.position !== '0) begin
      errors++;
      $display("FAIL reset_cnt_pos got %0d/%0d want 0/0", bus.step_count, bus.position);
    end
    checks++;
    if (bus.min_period !== ones || bus.max_period !== '0 || bus.last_period !== '0) begin
      errors++;
      $display("FAIL reset_periods got %h/%0d/%0d want ffffffff/0/0",
               bus.min_period, bus.max_period, bus.last_period);
    end
    checks++;
    if ({bus.busy, bus.done, bus.stall, bus.overrun, bus.period_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.busy, bus.done, bus.stall, bus.overrun, bus.period_valid});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int pv0;
    bus.dir_in = 1'b1;
    bus.expected_steps = 4;
    bus.enable = 1'b1;
    pv0 = pv_total;
    @(negedge clk);
    repeat (4) pulse(5, 5);
    repeat (5) @(negedge clk);
    pos_model = pos_model + 4;
    checks++;
    if (bus.step_count !== 4) begin
      errors++;
      $display("FAIL basic_count got %0d want 4", bus.step_count);
    end
    checks++;
    if (bus.last_period !== 10 || bus.min_period !== 10 || bus.max_period !== 10) begin
      errors++;
      $display("FAIL basic_periods got %0d/%0d/%0d want 10/10/10",
               bus.last_period, bus.min_period, bus.max_period);
    end
    checks++;
    if (pv_total - pv0 !== 3) begin
      errors++;
      $display("FAIL basic_pv got %0d want 3", pv_total - pv0);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.position !== pos_model) begin
      errors++;
      $display("FAIL basic_done_pos got %b/%b/%0d want 1/0/%0d",
               bus.done, bus.busy, bus.position, pos_model);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.step_count !== '0 || bus.min_period !== ones || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_clear got %0d/%h/%b want 0/ffffffff/0",
               bus.step_count, bus.min_period, bus.done);
    end
  endtask

  task automatic test_periods();
    int pv0;
    bus.dir_in = 1'b1;
    bus.expected_steps = 5;
    bus.enable = 1'b1;
    pv0 = pv_total;
    @(negedge clk);
    pulse(5, 15);
    pulse(5, 10);
    pulse(5, 5);
    pulse(5, 10);
    bus.step_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.step_count !== 4) begin
      errors++;
      $display("FAIL periods_early got done=%b cnt=%0d want 0/4", bus.done, bus.step_count);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.step_count !== 5) begin
      errors++;
      $display("FAIL periods_latency got done=%b cnt=%0d want 1/5", bus.done, bus.step_count);
    end
    repeat (2) @(negedge clk);
    bus.step_in = 1'b0;
    repeat (4) @(negedge clk);
    pos_model = pos_model + 5;
    checks++;
    if (bus.last_period !== 15 || bus.min_period !== 10 || bus.max_period !== 20) begin
      errors++;
      $display("FAIL periods_vals got %0d/%0d/%0d want 15/10/20",
               bus.last_period, bus.min_period, bus.max_period);
    end
    checks++;
    if (pv_total - pv0 !== 4) begin
      errors++;
      $display("FAIL periods_pv got %0d want 4", pv_total - pv0);
    end
    bus.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int unsigned exp_n, n, k, pv0;
      logic d;
      logic [W-1:0] lastm, minm, maxm;
      int unsigned gaps[$];
      exp_n = $urandom_range(2, 6);
      n = $urandom_range(1, exp_n + 1);
      d = 1'($urandom_range(0, 1));
      gaps = {};
      for (int i = 0; i < int'(n) - 1; i++) gaps.push_back($urandom_range(3, 30));
      bus.dir_in = d;
      bus.expected_steps = exp_n;
      bus.enable = 1'b1;
      pv0 = pv_total;
      @(negedge clk);
      for (int i = 0; i < int'(n) - 1; i++) pulse(int'(gaps[i] / 2), int'(gaps[i] - gaps[i] / 2));
      pulse(2, 2);
      repeat (130) @(negedge clk);
      // Reference: periods only count between the first min(n, expected) pulses.
      k = (n < exp_n) ? n : exp_n;
      lastm = '0;
      minm = ones;
      maxm = '0;
      for (int i = 0; i < int'(k) - 1; i++) begin
        lastm = W'(gaps[i]);
        if (W'(gaps[i]) < minm) minm = W'(gaps[i]);
        if (W'(gaps[i]) > maxm) maxm = W'(gaps[i]);
      end
      pos_model = d ? pos_model + W'(n) : pos_model - W'(n);
      checks++;
      if (bus.step_count !== W'(n) || bus.position !== pos_model) begin
        errors++;
        $display("FAIL rand%0d_cnt_pos got %0d/%0d want %0d/%0d",
                 it, bus.step_count, bus.position, n, pos_model);
      end
      checks++;
      if ({bus.done, bus.stall, bus.overrun} !== {n >= exp_n, n < exp_n, n > exp_n}) begin
        errors++;
        $display("FAIL rand%0d_flags got %b want %b", it,
                 {bus.done, bus.stall, bus.overrun}, {n >= exp_n, n < exp_n, n > exp_n});
      end
      checks++;
      if (bus.last_period !== lastm || bus.min_period !== minm || bus.max_period !== maxm) begin
        errors++;
        $display("FAIL rand%0d_periods got %0d/%0d/%0d want %0d/%0d/%0d", it,
                 bus.last_period, bus.min_period, bus.max_period, lastm, minm, maxm);
      end
      checks++;
      if (pv_total - int'(pv0) !== int'(k) - 1) begin
        errors++;
        $display("FAIL rand%0d_pv got %0d want %0d", it, pv_total - int'(pv0), int'(k) - 1);
      end
      bus.enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    bus.expected_steps = 3;
    bus.enable = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_early got stall=%b busy=%b want 0/1", bus.stall, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_hit got stall=%b busy=%b want 1/0", bus.stall, bus.busy);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear got %b want 0", bus.stall);
    end
  endtask

  task automatic test_overrun();
    bus.dir_in = 1'b1;
    bus.expected_steps = 2;
    bus.enable = 1'b1;
    @(negedge clk);
    repeat (2) pulse(5, 5);
    checks++;
    if (bus.done !== 1'b1 || bus.overrun !== 1'b0 || bus.step_count !== 2) begin
      errors++;
      $display("FAIL ovr_before got %b/%b/%0d want 1/0/2", bus.done, bus.overrun, bus.step_count);
    end
    pulse(5, 5);
    pos_model = pos_model + 3;
    checks++;
    if (bus.overrun !== 1'b1 || bus.step_count !== 3 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after got %b/%0d/%b want 1/3/1", bus.overrun, bus.step_count, bus.done);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b want 0", bus.overrun);
    end
    bus.dir_in = 1'b0;
    repeat (3) pulse(4, 4);
    repeat (3) @(negedge clk);
    pos_model = pos_model - 3;
    checks++;
    if (bus.position !== pos_model || bus.step_count !== '0) begin
      errors++;
      $display("FAIL idle_pos got %0d/%0d want %0d/0", bus.position, bus.step_count, pos_model);
    end
  endtask

  task automatic test_zero();
    bus.expected_steps = 0;
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    bus.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.dir_in = 1'b1;
    bus.expected_steps = 5;
    bus.enable = 1'b1;
    @(negedge clk);
    repeat (2) pulse(5, 5);
    bus.step_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    pos_model = '0;
    checks++;
    if (bus.step_count !== '0 || bus.position !== '0 || bus.min_period !== ones ||
        bus.last_period !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got cnt=%0d pos=%0d min=%h last=%0d busy=%b",
               bus.step_count, bus.position, bus.min_period, bus.last_period, bus.busy);
    end
    @(negedge clk);
    bus.step_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.step_count !== '0 || bus.position !== '0) begin
      errors++;
      $display("FAIL rstmid_noedge got cnt=%0d pos=%0d want 0/0", bus.step_count, bus.position);
    end
    bus.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_coincident();
    bus2.dir_in = 1'b1;
    bus2.expected_steps = 5;
    bus2.enable = 1'b1;
    repeat (5) pulse2(5, 5);
    repeat (3) @(negedge clk);
    pos2_model = pos2_model + 5;
    checks++;
    if (bus2.stall !== 1'b0 || bus2.done !== 1'b1 || bus2.step_count !== 5 ||
        bus2.last_period !== 10) begin
      errors++;
      $display("FAIL coinc got stall=%b done=%b cnt=%0d last=%0d want 0/1/5/10",
               bus2.stall, bus2.done, bus2.step_count, bus2.last_period);
    end
    bus2.enable = 1'b0;
    @(negedge clk);
    bus2.expected_steps = 3;
    bus2.enable = 1'b1;
    repeat (3) pulse2(5, 6);
    repeat (3) @(negedge clk);
    pos2_model = pos2_model + 3;
    checks++;
    if (bus2.stall !== 1'b1 || bus2.done !== 1'b0 || bus2.step_count !== 3 ||
        bus2.last_period !== '0) begin
      errors++;
      $display("FAIL late_stall got stall=%b done=%b cnt=%0d last=%0d want 1/0/3/0",
               bus2.stall, bus2.done, bus2.step_count, bus2.last_period);
    end
    checks++;
    if (bus2.position !== pos2_model) begin
      errors++;
      $display("FAIL pos2 got %0d want %0d", bus2.position, pos2_model);
    end
    bus2.enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.expected_steps = '0;
    bus.step_in = 1'b0;
    bus.dir_in = 1'b0;
    bus2.enable = 1'b0;
    bus2.expected_steps = '0;
    bus2.step_in = 1'b0;
    bus2.dir_in = 1'b0;
    test_reset();
    test_basic();
    test_periods();
    test_random();
    test_stall();
    test_overrun();
    test_zero();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
